seg7_digit_decoder: RTL
=======================

# seg7_digit_decoder

Receive-side counterpart of the hex-to-seven-segment encoder. Accepts a stream of active-low 7-segment patterns over a valid/ready handshake, maps each back to its 4-bit hex value, and packs DIGITS consecutive digits MSB-first into one word. Sits behind the SPI display link, so the MCU side can read back what the panel is being driven with. Flags illegal patterns, supports frame resynchronisation, and keeps a saturating error count.

## Interface
- DIGITS, 4: nibbles per output word, 1..8.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous and active-low, sampled on rising clk.
- seg_in  in  7  segment pattern, active-low; bit6=g … bit0=a.
- seg_valid  in  1  seg_in holds a digit.
- seg_sync  in  1  qualified by seg_valid; this digit is the first of a new word.
- seg_ready  out  1  block accepts the digit this cycle.
- word_out  out  4*DIGITS  packed word; first received digit in the top nibble.
- err_mask  out  DIGITS  bit i set means nibble i of word_out came from an illegal pattern.
- word_valid  out  1  word_out/err_mask valid.
- word_ready  in  1  consumer takes the word.
- drop_pulse  out  1  one-cycle pulse when a partial word is discarded by seg_sync.
- err_count  out  ERR_CNT_W  illegal patterns seen, saturating at all-ones.

## Operation
- A digit is accepted on a cycle where seg_valid && seg_ready.
- Decode map is an exact inverse of the encoder (seg_in hex value -> nibble):
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3
  - 0x19→4, 0x12→5, 0x02→6, 0x78→7
  - 0x00→8, 0x10→9, 0x08→A, 0x03→B
  - 0x46→C, 0x21→D, 0x06→E, 0x0E→F
- Any other pattern is illegal. It decodes to nibble 0, sets that digit's err_mask bit, and increments err_count (saturating).
- Assembly holds a shift register plus a digit counter `cnt` (0..DIGITS-1).
  - Each accepted digit shifts in at the low nibble: asm = {asm[4*DIGITS-5:0], nib}.
  - The error bits shift the same way.
- States:
  - COLLECT: cnt < DIGITS-1.
  - LAST: cnt == DIGITS-1.
- Accepting a digit in LAST copies the completed assembly (including the new digit) into the output register, sets word_valid, clears cnt, and returns to COLLECT.
- Output register: word_valid stays high until word_valid && word_ready. word_out and err_mask hold stable while word_valid && !word_ready.
- seg_ready = !(cnt == DIGITS-1 && word_valid && !word_ready). Only completing a word can stall the stream.
- seg_sync with an accepted digit:
  - If cnt != 0: discard the partial assembly, pulse drop_pulse, and treat this digit as digit 0.
  - If cnt == 0: no drop.
- DIGITS == 1: every accepted digit is LAST. seg_sync never drops.

## Timing
- Reset values:
  - seg_ready=1, word_valid=0, word_out=0, err_mask=0, drop_pulse=0, err_count=0.
  - cnt=0, assembly=0.
- Latency: word_valid rises the cycle after the final digit is accepted.
- Throughput: one digit per clock sustained while word_ready=1.
- Simultaneous events in LAST, when word_valid=1 and word_ready=1 on the same cycle: the old word is consumed and the new word is loaded. word_valid stays 1 with no bubble.
- Simultaneous illegal digit and seg_sync: the drop happens, then the new digit 0 is marked in error, and err_count increments once.
- err_count at all-ones stays at all-ones.
- rst_n low mid-word or with word_valid pending: everything returns to reset values on that edge. Pending data is lost and drop_pulse is not asserted.
- drop_pulse is registered and asserts exactly one cycle after the dropping accept.

## Test plan
- DIGITS=4. Send 0x40,0x79,0x24,0x30 with word_ready=1 → word_out=0x0123, err_mask=0000, word_valid for 1 cycle.
- Send 0x06,0x7F,0x0E,0x00 → word_out=0xE0F8, err_mask=0100, err_count=1.
- Hold word_ready=0 after the first word, then stream 4 more digits → seg_ready drops on the 4th digit; the first word stays stable. Raise word_ready → the second word loads on the next accept with no bubble.
- Send 0x40,0x79, then 0x08 with seg_sync, then 0x03,0x46,0x21 → drop_pulse once, word_out=0xABCD.
- Send 2 digits, assert rst_n=0 for one cycle, then send 4 digits → only the post-reset word appears, with err_count=0.
- Send 300 illegal 0x7F digits with ERR_CNT_W=8 → err_count=255 and stays there. Words are 0x0000 with err_mask=1111.

Source files
------------

// File: rtl/seg7_digit_decoder_if.sv
// Digit stream in / packed word out handshake bundle for seg7_digit_decoder.
// slave is the decoder's view, master is the view of whoever drives digits
// and takes words.
interface seg7_digit_decoder_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg_in;
  logic                seg_valid;
  logic                seg_sync;
  logic                seg_ready;
  logic [4*DIGITS-1:0] word_out;
  logic [DIGITS-1:0]   err_mask;
  logic                word_valid;
  logic                word_ready;

  modport slave (
    input  seg_in, seg_valid, seg_sync, word_ready,
    output seg_ready, word_out, err_mask, word_valid
  );

  modport master (
    output seg_in, seg_valid, seg_sync, word_ready,
    input  seg_ready, word_out, err_mask, word_valid
  );
endinterface

// File: rtl/seg7_digit_decoder.sv
// Decodes active-low 7-segment patterns back to hex nibbles and packs DIGITS
// of them, first digit in the top nibble, into one output word. Illegal
// patterns decode to 0, are flagged per nibble and counted (saturating).
//
// state   | meaning
// COLLECT | cnt < DIGITS-1, next accepted digit only extends the assembly
// LAST    | cnt == DIGITS-1, next accepted digit completes the word
module seg7_digit_decoder #(
  parameter int DIGITS    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_digit_decoder_if.slave  bus,
  output logic                 drop_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  typedef enum logic {COLLECT, LAST} state_t;

  // With a single digit per word every digit completes a word.
  localparam state_t RST_STATE = (DIGITS == 1) ? LAST : COLLECT;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [W-1:0]         asm_q, asm_d;
  logic [DIGITS-1:0]    asm_err_q, asm_err_d;
  logic [W-1:0]         word_q, word_d;
  logic [DIGITS-1:0]    mask_q, mask_d;
  logic                 wvalid_q, wvalid_d;
  logic                 drop_q, drop_d;
  logic [ERR_CNT_W-1:0] errc_q, errc_d;

  logic [3:0]        nib;
  logic              legal;
  logic              seg_ready;
  logic              accept;
  logic [CNT_W-1:0]  eff_cnt;
  logic [W-1:0]      base_asm, new_asm;
  logic [DIGITS-1:0] base_err, new_err;

  // Inverse of the hex-to-segment encoder; anything else is illegal.
  always_comb begin
    nib   = 4'h0;
    legal = 1'b1;
    case (bus.seg_in)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  // Next-state: assembly, word hand-off, resync drop and error counting.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    asm_err_d = asm_err_q;
    word_d    = word_q;
    mask_d    = mask_q;
    wvalid_d  = wvalid_q;
    drop_d    = 1'b0;
    errc_d    = errc_q;
    eff_cnt   = cnt_q;
    base_asm  = asm_q;
    base_err  = asm_err_q;
    new_asm   = '0;
    new_err   = '0;

    // Only a completing digit can stall, and only while the old word is held.
    seg_ready = !(state_q == LAST && wvalid_q && !bus.word_ready);
    accept    = bus.seg_valid && seg_ready;

    if (wvalid_q && bus.word_ready) wvalid_d = 1'b0;

    if (accept) begin
      if (bus.seg_sync) begin
        if (cnt_q != '0) drop_d = 1'b1;
        base_asm = '0;
        base_err = '0;
        eff_cnt  = '0;
      end
      new_asm = (base_asm << 4) | W'(nib);
      new_err = (base_err << 1) | DIGITS'(!legal);

      if (eff_cnt == LAST_CNT) begin
        // Loading here also covers a same-cycle consume: no bubble.
        word_d    = new_asm;
        mask_d    = new_err;
        wvalid_d  = 1'b1;
        cnt_d     = '0;
        asm_d     = '0;
        asm_err_d = '0;
      end else begin
        cnt_d     = eff_cnt + CNT_W'(1);
        asm_d     = new_asm;
        asm_err_d = new_err;
      end

      if (!legal && errc_q != '1) errc_d = errc_q + ERR_CNT_W'(1);
    end

    state_d = (cnt_d == LAST_CNT) ? LAST : COLLECT;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      cnt_q     <= '0;
      asm_q     <= '0;
      asm_err_q <= '0;
      word_q    <= '0;
      mask_q    <= '0;
      wvalid_q  <= 1'b0;
      drop_q    <= 1'b0;
      errc_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      asm_err_q <= asm_err_d;
      word_q    <= word_d;
      mask_q    <= mask_d;
      wvalid_q  <= wvalid_d;
      drop_q    <= drop_d;
      errc_q    <= errc_d;
    end
  end

  assign bus.seg_ready  = seg_ready;
  assign bus.word_out   = word_q;
  assign bus.err_mask   = mask_q;
  assign bus.word_valid = wvalid_q;
  assign drop_pulse     = drop_q;
  assign err_count      = errc_q;

endmodule
